// File: rtl/md5_pkg.sv
// Shared MD5 constants, tables, round helpers and FSM state encoding.
package md5_pkg;

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

   typedef logic [1:0] md5_state_t;
   localparam md5_state_t ST_IDLE = 2'd0;
   localparam md5_state_t ST_RUN  = 2'd1;
   localparam md5_state_t ST_DONE = 2'd2;

   // floor(2^32 * |sin(i+1)|)
   localparam logic [31:0] K_TAB [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   // Rotation amounts, indexed by {round, step mod 4}
   localparam logic [4:0] S_TAB [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22,
      5'd5, 5'd9,  5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23,
      5'd6, 5'd10, 5'd15, 5'd21
   };

   // Nonlinear function of round r (F, G, H, I)
   function automatic logic [31:0] round_fn(input logic [1:0] r, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
      logic [31:0] f;
      case (r)
         2'd0:    f = (b & c) | (~b & d);
         2'd1:    f = (b & d) | (c & ~d);
         2'd2:    f = b ^ c ^ d;
         default: f = c ^ (b | ~d);
      endcase
      return f;
   endfunction

   // Message word index g(i); 4-bit arithmetic gives the mod 16 for free
   function automatic logic [3:0] msg_idx(input logic [5:0] i);
      logic [3:0] ii;
      logic [3:0] g;
      ii = i[3:0];
      case (i[5:4])
         2'd0:    g = ii;
         2'd1:    g = ii * 4'd5 + 4'd1;
         2'd2:    g = ii * 4'd3 + 4'd5;
         default: g = ii * 4'd7;
      endcase
      return g;
   endfunction

   function automatic logic [4:0] shift_amt(input logic [5:0] i);
      return S_TAB[{i[5:4], i[1:0]}];
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
      return (x << s) | (x >> (6'd32 - {1'b0, s}));
   endfunction

endpackage

// File: rtl/md5_iter_core_if.sv
// Block-in / digest-out handshake bundle for the MD5 core.
interface md5_iter_core_if #(
   parameter int TAG_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [511:0]     in_block;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_digest;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_block, in_tag, out_ready,
      input  in_ready, out_valid, out_digest, out_tag
   );

   modport slave (
      input  in_valid, in_block, in_tag, out_ready,
      output in_ready, out_valid, out_digest, out_tag
   );
endinterface

// File: rtl/md5_step.sv
// One combinational MD5 step; the step index selects round function, K, S and message word.
module md5_step
   import md5_pkg::*;
(
   input  logic [31:0]  a_i,
   input  logic [31:0]  b_i,
   input  logic [31:0]  c_i,
   input  logic [31:0]  d_i,
   input  logic [5:0]   idx_i,
   input  logic [511:0] blk_i,
   output logic [31:0]  a_o,
   output logic [31:0]  b_o,
   output logic [31:0]  c_o,
   output logic [31:0]  d_o
);

   logic [31:0] words [16];
   logic [31:0] t_w;

   for (genvar j = 0; j < 16; j++) begin : g_word
      assign words[j] = blk_i[511-32*j -: 32];
   end

   // t = A + F + K + M, then rotate the register file one position
   always_comb begin
      t_w = a_i + round_fn(idx_i[5:4], b_i, c_i, d_i) + K_TAB[idx_i] + words[msg_idx(idx_i)];
      a_o = d_i;
      b_o = b_i + rotl(t_w, shift_amt(idx_i));
      c_o = b_i;
      d_o = c_i;
   end

endmodule

// File: rtl/md5_iter_core.sv
// Iterative MD5 compression core: STEPS_PER_CYCLE chained steps per clock, 64 steps per block.
module md5_iter_core
   import md5_pkg::*;
#(
   parameter int STEPS_PER_CYCLE = 1,
   parameter int TAG_W           = 32,
   parameter int FINAL_ADD       = 1
) (
   input logic            clk,
   input logic            rst,
   md5_iter_core_if.slave bus_if
);

   if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4 ||
         STEPS_PER_CYCLE == 8 || STEPS_PER_CYCLE == 16)) begin : g_bad_spc
      $error("md5_iter_core: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   // Counter value at the start of the group that contains step 63
   localparam logic [5:0] LAST_CNT = 6'(64 - STEPS_PER_CYCLE);
   localparam logic [5:0] CNT_INC  = 6'(STEPS_PER_CYCLE);

   md5_state_t       state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [511:0]     blk_q, blk_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [TAG_W-1:0] otag_q, otag_d;
   logic [31:0]      a_q, b_q, c_q, d_q;
   logic [31:0]      a_d, b_d, c_d, d_d;
   logic [127:0]     dig_q, dig_d;

   logic [31:0] ch_a [STEPS_PER_CYCLE+1];
   logic [31:0] ch_b [STEPS_PER_CYCLE+1];
   logic [31:0] ch_c [STEPS_PER_CYCLE+1];
   logic [31:0] ch_d [STEPS_PER_CYCLE+1];

   assign ch_a[0] = a_q;
   assign ch_b[0] = b_q;
   assign ch_c[0] = c_q;
   assign ch_d[0] = d_q;

   // Step k of the group works on step index cnt_q + k
   for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
      md5_step u_step (
         .a_i   (ch_a[k]),
         .b_i   (ch_b[k]),
         .c_i   (ch_c[k]),
         .d_i   (ch_d[k]),
         .idx_i (cnt_q + 6'(k)),
         .blk_i (blk_q),
         .a_o   (ch_a[k+1]),
         .b_o   (ch_b[k+1]),
         .c_o   (ch_c[k+1]),
         .d_o   (ch_d[k+1])
      );
   end

   // Next-state: accept in IDLE, iterate in RUN, hold the result in DONE until taken
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      tag_d   = tag_q;
      otag_d  = otag_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      dig_d   = dig_q;
      case (state_q)
         ST_IDLE: begin
            if (bus_if.in_valid) begin
               blk_d   = bus_if.in_block;
               tag_d   = bus_if.in_tag;
               a_d     = IV_A;
               b_d     = IV_B;
               c_d     = IV_C;
               d_d     = IV_D;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d   = ch_a[STEPS_PER_CYCLE];
            b_d   = ch_b[STEPS_PER_CYCLE];
            c_d   = ch_c[STEPS_PER_CYCLE];
            d_d   = ch_d[STEPS_PER_CYCLE];
            cnt_d = cnt_q + CNT_INC;
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
               otag_d  = tag_q;
               if (FINAL_ADD != 0) begin
                  dig_d = {ch_a[STEPS_PER_CYCLE] + IV_A, ch_b[STEPS_PER_CYCLE] + IV_B,
                           ch_c[STEPS_PER_CYCLE] + IV_C, ch_d[STEPS_PER_CYCLE] + IV_D};
               end else begin
                  dig_d = {ch_a[STEPS_PER_CYCLE], ch_b[STEPS_PER_CYCLE],
                           ch_c[STEPS_PER_CYCLE], ch_d[STEPS_PER_CYCLE]};
               end
            end
         end
         ST_DONE: begin
            if (bus_if.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and visible outputs: reset drops any in-flight block
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dig_q   <= '0;
         otag_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         otag_q  <= otag_d;
      end
   end

   // Working data: only meaningful while RUN, so no reset needed
   always_ff @(posedge clk) begin
      blk_q <= blk_d;
      tag_q <= tag_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      d_q   <= d_d;
   end

   assign bus_if.in_ready   = (state_q == ST_IDLE);
   assign bus_if.out_valid  = (state_q == ST_DONE);
   assign bus_if.out_digest = dig_q;
   assign bus_if.out_tag    = otag_q;

endmodule

// File: tb/tb_md5_iter_core.sv
// Bench for md5_iter_core: six cores (STEPS_PER_CYCLE 1..16 with final add, plus 1 without).
module tb_md5_iter_core;

   localparam int NDUT = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         iv   [NDUT];
   logic [511:0] ib   [NDUT];
   logic [31:0]  itag [NDUT];
   logic         ordy [NDUT];
   logic         ir   [NDUT];
   logic         ov   [NDUT];
   logic [127:0] od   [NDUT];
   logic [31:0]  ot   [NDUT];

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      localparam int SPC = (k == 5) ? 1 : (1 << k);
      localparam int FA  = (k == 5) ? 0 : 1;
      md5_iter_core_if #(.TAG_W(32)) bus ();
      assign bus.in_valid  = iv[k];
      assign bus.in_block  = ib[k];
      assign bus.in_tag    = itag[k];
      assign bus.out_ready = ordy[k];
      assign ir[k] = bus.in_ready;
      assign ov[k] = bus.out_valid;
      assign od[k] = bus.out_digest;
      assign ot[k] = bus.out_tag;
      md5_iter_core #(.STEPS_PER_CYCLE(SPC), .TAG_W(32), .FINAL_ADD(FA)) u_dut (
         .clk    (clk),
         .rst    (rst),
         .bus_if (bus.slave)
      );
   end

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] kref [64];
   int sref [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

   function automatic int spc_of(input int k);
      return (k == 5) ? 1 : (1 << k);
   endfunction

   function automatic logic [31:0] rl(input logic [31:0] x, input int s);
      return (x << s) | (x >> (32 - s));
   endfunction

   // Plain RFC 1321 compression of one block
   function automatic logic [127:0] md5_model(input logic [511:0] blk, input bit fa);
      logic [31:0] m [16];
      logic [31:0] a, b, c, d, f, tmp;
      int g;
      for (int j = 0; j < 16; j++) m[j] = blk[511-32*j -: 32];
      a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
      for (int i = 0; i < 64; i++) begin
         if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
         else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
         else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
         else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
         tmp = d;
         d = c;
         c = b;
         b = b + rl(a + f + kref[i] + m[g], sref[i / 16][i % 4]);
         a = tmp;
      end
      if (fa) return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
      return {a, b, c, d};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic accept(input int k, input logic [511:0] blk, input logic [31:0] tag);
      iv[k] = 1'b1;
      ib[k] = blk;
      itag[k] = tag;
      tick();
      iv[k] = 1'b0;
      chk("busy_after_accept", 128'(ir[k]), 128'(0));
   endtask

   task automatic wait_valid(input int k, input string tag);
      int n;
      n = 0;
      while (!ov[k] && n < 300) begin
         tick();
         n++;
      end
      chk(tag, 128'(n), 128'(64 / spc_of(k)));
   endtask

   task automatic handshake(input int k);
      ordy[k] = 1'b1;
      tick();
      chk("valid_drop_after_xfer", 128'(ov[k]), 128'(0));
      chk("ready_after_xfer", 128'(ir[k]), 128'(1));
      ordy[k] = 1'b0;
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] b;
      for (int j = 0; j < 16; j++) b[511-32*j -: 32] = $urandom;
      return b;
   endfunction

   logic [511:0] blk_empty, blk_abc;
   logic [31:0]  rtag;
   logic [511:0] blks [4];
   logic [31:0]  tags [4];
   logic [127:0] exp_d [4];
   int           acc_cyc [4];
   int           nin, nout, guard;
   bit           acc, xfer;
   logic [127:0] d_s;
   logic [31:0]  t_s;

   initial begin
      for (int i = 0; i < 64; i++) begin
         real s;
         s = $sin(real'(i + 1));
         if (s < 0.0) s = -s;
         kref[i] = 32'(longint'($floor(4294967296.0 * s)));
      end
      for (int k = 0; k < NDUT; k++) begin
         iv[k] = 1'b0; ib[k] = '0; itag[k] = '0; ordy[k] = 1'b0;
      end
      blk_empty = '0;
      blk_empty[511 -: 32] = 32'h00000080;
      blk_abc = '0;
      blk_abc[511 -: 32] = 32'h80636261;
      blk_abc[63:32]     = 32'h00000018;

      // Reset state of every core
      rst = 1'b1;
      tick();
      tick();
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_in_ready", 128'(ir[k]), 128'(1));
         chk("rst_out_valid", 128'(ov[k]), 128'(0));
         chk("rst_digest", od[k], 128'(0));
         chk("rst_tag", 128'(ot[k]), 128'(0));
      end
      rst = 1'b0;
      tick();

      // Empty string, one step per cycle
      rtag = $urandom;
      accept(0, blk_empty, rtag);
      wait_valid(0, "empty_latency");
      chk("empty_digest", od[0], 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec);
      chk("empty_digest_model", od[0], md5_model(blk_empty, 1'b1));
      chk("empty_tag", 128'(ot[0]), 128'(rtag));
      handshake(0);

      // "abc", four steps per cycle, then backpressure in DONE
      accept(2, blk_abc, 32'h0000abcd);
      wait_valid(2, "abc_latency");
      chk("abc_digest", od[2], 128'h98500190_b04fd23c_7d3f96d6_727fe128);
      chk("abc_tag", 128'(ot[2]), 128'h0000abcd);
      for (int c = 0; c < 10; c++) begin
         iv[2] = c[0];
         ib[2] = rand_blk();
         itag[2] = $urandom;
         tick();
         chk("bp_valid_held", 128'(ov[2]), 128'(1));
         chk("bp_in_ready_low", 128'(ir[2]), 128'(0));
         chk("bp_digest_stable", od[2], 128'h98500190_b04fd23c_7d3f96d6_727fe128);
         chk("bp_tag_stable", 128'(ot[2]), 128'h0000abcd);
      end
      iv[2] = 1'b0;
      handshake(2);
      tick();
      chk("bp_no_stray_accept", 128'(ir[2]), 128'(1));

      // Empty string without the final IV add
      accept(5, blk_empty, 32'h5);
      wait_valid(5, "nofa_latency");
      chk("nofa_digest", od[5], 128'h7246fad3_14e45506_ff4ea3eb_6e10a476);
      chk("nofa_digest_model", od[5], md5_model(blk_empty, 1'b0));
      handshake(5);

      // Reset in the middle of RUN, with in_valid held high across it
      accept(0, rand_blk(), 32'hdead0001);
      for (int c = 0; c < 30; c++) tick();
      iv[0] = 1'b1;
      ib[0] = blk_abc;
      itag[0] = 32'h00000077;
      rst = 1'b1;
      tick();
      chk("midrst_valid", 128'(ov[0]), 128'(0));
      chk("midrst_digest", od[0], 128'(0));
      chk("midrst_tag", 128'(ot[0]), 128'(0));
      chk("midrst_in_ready", 128'(ir[0]), 128'(1));
      rst = 1'b0;
      tick();
      iv[0] = 1'b0;
      chk("midrst_reaccept", 128'(ir[0]), 128'(0));
      wait_valid(0, "midrst_latency");
      chk("midrst_abc_digest", od[0], 128'h98500190_b04fd23c_7d3f96d6_727fe128);
      chk("midrst_abc_tag", 128'(ot[0]), 128'h00000077);
      handshake(0);

      // Back-to-back random blocks on every legal step count
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) begin
            blks[i]  = rand_blk();
            tags[i]  = $urandom;
            exp_d[i] = md5_model(blks[i], 1'b1);
         end
         nin = 0; nout = 0; guard = 0;
         ordy[k] = 1'b1;
         iv[k]   = 1'b1;
         ib[k]   = blks[0];
         itag[k] = tags[0];
         while (nout < 4 && guard < 1000) begin
            acc  = ir[k] && iv[k];
            xfer = ov[k] && ordy[k];
            d_s  = od[k];
            t_s  = ot[k];
            tick();
            guard++;
            if (xfer) begin
               chk("b2b_digest", d_s, exp_d[nout]);
               chk("b2b_tag", 128'(t_s), 128'(tags[nout]));
               nout++;
            end
            if (acc) begin
               acc_cyc[nin] = cyc;
               nin++;
               if (nin < 4) begin
                  ib[k]   = blks[nin];
                  itag[k] = tags[nin];
               end else begin
                  iv[k] = 1'b0;
               end
            end
         end
         iv[k] = 1'b0;
         ordy[k] = 1'b0;
         chk("b2b_count", 128'(nout), 128'(4));
         if (nin == 4) begin
            for (int i = 1; i < 4; i++)
               chk("b2b_interval", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(64 / spc_of(k) + 2));
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/md5_iter_core.md
# md5_iter_core

Iterative, parametrised MD5 compression engine for the hash-breaker datapath. It accepts one pre-padded 512-bit block with a candidate tag and runs all 64 MD5 steps, executing `STEPS_PER_CYCLE` steps per clock. It returns the 128-bit digest and tag over valid/ready handshakes. It replaces a fixed 64-stage step pipeline where area matters more than throughput; several cores sit side by side behind the candidate generator.

## Interface
- `STEPS_PER_CYCLE`, default 1: steps per clock; legal values 1, 2, 4, 8, 16. Any other value is an elaboration error.
- `TAG_W`, default 32: width of the candidate tag carried through unchanged.
- `FINAL_ADD`, default 1: 1 gives IV + working state (true digest); 0 gives raw A,B,C,D after step 63.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: block offered.
- `in_ready` output 1: core idle and able to accept.
- `in_block` input 512: message block; word j = `in_block[511-32j -: 32]`, already in MD5 little-endian word order.
- `in_tag` input TAG_W: candidate identifier.
- `out_valid` output 1: digest available.
- `out_ready` input 1: consumer accepts.
- `out_digest` output 128: {A,B,C,D}, A in [127:96].
- `out_tag` output TAG_W: tag of the block that produced `out_digest`.

## Operation
- FSM states IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid` & `in_ready`:
  - latch block and tag;
  - load A,B,C,D = 67452301, efcdab89, 98badcfe, 10325476;
  - step counter = 0;
  - go to RUN.
- RUN: each cycle applies `STEPS_PER_CYCLE` consecutive steps i, chained combinationally.
  - Step i: t = A + F_r(B,C,D) + K[i] + M[g(i)]; new (A,B,C,D) = (D, B + rotl(t, S[i]), B, C).
  - All arithmetic is mod 2^32.
  - Round r = i/16:
    - r=0: F = (B&C)|(~B&D), g = i.
    - r=1: G = (B&D)|(C&~D), g = (5i+1) mod 16.
    - r=2: H = B^C^D, g = (3i+5) mod 16.
    - r=3: I = C^(B|~D), g = 7i mod 16.
  - Every step uses the function, K and S of its own round. No function is shared across rounds.
  - Counter advances by `STEPS_PER_CYCLE`. When the group containing step 63 completes, register the result into `out_digest` (IV-added if `FINAL_ADD`), register `out_tag`, and go to DONE.
- DONE: `out_valid`=1; `out_digest`/`out_tag` held stable. On `out_ready` go to IDLE.
- `in_ready` is 0 in RUN and DONE. No input is accepted while busy.
- `out_valid` is never dropped without `out_ready`.
- Reset, including mid-RUN or mid-DONE: state IDLE, `out_valid`=0, `out_digest`=0, `out_tag`=0, counter 0. The in-flight block is discarded with no output. `in_ready`=1 from the first cycle after reset.

## Timing
- Accept edge to `out_valid` high: 64/`STEPS_PER_CYCLE` cycles (64, 32, 16, 8, 4).
- Handshake to next `in_ready`: `out_valid` & `out_ready` at edge n puts the core in IDLE at n+1. Initiation interval = 64/`STEPS_PER_CYCLE` + 2 cycles when `out_ready` is held high.
- `in_ready` and `out_valid` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- Critical path: `STEPS_PER_CYCLE` chained step adders.

## Structure
- Package `md5_pkg` holds:
  - K[0..63] table (floor(2^32·|sin(i+1)|));
  - S table: r0 7,12,17,22; r1 5,9,14,20; r2 4,11,16,23; r3 6,10,15,21;
  - IV constants;
  - round functions and message index function g(i);
  - FSM state enum.
- Sub-module `md5_step`: purely combinational single step with inputs A,B,C,D, step index and 512-bit block, and output next A,B,C,D. Instantiated `STEPS_PER_CYCLE` times in a chain; `md5_iter_core` contains only the FSM, counter and registers.

## Test plan
- Empty string (M[0]=00000080, rest 0), `FINAL_ADD`=1, `STEPS_PER_CYCLE`=1 → `out_digest`=d98c1dd4_04b2008f_980980e9_7e42f8ec, `out_valid` exactly 64 cycles after accept.
- "abc" (M[0]=80636261, M[14]=00000018), `STEPS_PER_CYCLE`=4, tag=0000abcd → `out_digest`=98500190_b04fd23c_7d3f96d6_727fe128, `out_tag`=0000abcd, latency 16.
- Backpressure: `out_ready` held 0 for 10 cycles in DONE → `out_digest`/`out_tag` stable, `in_ready`=0, `in_valid` pulses ignored. Release → one transfer, `in_ready`=1 next cycle.
- Empty string with `FINAL_ADD`=0 → `out_digest` = empty-string digest minus IV, word-wise mod 2^32.
- `rst` asserted at RUN step 30, `in_valid` held high → no `out_valid`, outputs 0, `in_ready`=1 the cycle after reset. A new "abc" block then gives the correct digest.
- Back-to-back blocks with `in_valid` and `out_ready` held high, all legal `STEPS_PER_CYCLE` values → digests match the reference model, tags stay in order.
